// File: rtl/branch_predictor.sv
// Bimodal branch predictor with a direct-mapped BTB and saturating misprediction counter.
// Define GSHARE_EN to XOR a global history register into the counter index (gshare).
module branch_predictor #(
  parameter int BHT_ENTRIES = 16,
  parameter int GHR_BITS    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        predict_taken,
  output logic [31:0] branch_target,
  output logic        btb_hit,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        update_predicted,
  output logic [15:0] mispredict_count
);

  localparam int IdxW = $clog2(BHT_ENTRIES);
  localparam int TagW = 30 - IdxW;

  if (BHT_ENTRIES < 4 || BHT_ENTRIES > 256 || (BHT_ENTRIES & (BHT_ENTRIES - 1)) != 0 ||
      GHR_BITS < 1 || GHR_BITS > IdxW) begin : gBadParams
    $error("branch_predictor: illegal BHT_ENTRIES/GHR_BITS combination");
  end

  logic [1:0]         counter_q [BHT_ENTRIES];
  logic [1:0]         counter_d;
  logic [BHT_ENTRIES-1:0] valid_q;
  logic [TagW-1:0]    tag_q     [BHT_ENTRIES];
  logic [31:0]        target_q  [BHT_ENTRIES];
  logic [15:0]        mispredCnt_q, mispredCnt_d;

  logic [IdxW-1:0]    lookupIdx, lookupCntIdx, updateIdx, updateCntIdx;
  logic [TagW-1:0]    lookupTag, updateTag;
  logic               unusedUpdPcBits;

  assign lookupIdx       = pc[IdxW+1:2];
  assign lookupTag       = pc[31:IdxW+2];
  assign updateIdx       = update_pc[IdxW+1:2];
  assign updateTag       = update_pc[31:IdxW+2];
  assign unusedUpdPcBits = ^update_pc[1:0];

`ifdef GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q, ghr_d;

  // Both lookup and update hash with the current (pre-shift) history.
  assign lookupCntIdx = lookupIdx ^ IdxW'(ghr_q);
  assign updateCntIdx = updateIdx ^ IdxW'(ghr_q);
  assign ghr_d        = (ghr_q << 1) | GHR_BITS'(update_taken);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q <= '0;
    end else if (update_valid) begin
      ghr_q <= ghr_d;
    end
  end
`else
  assign lookupCntIdx = lookupIdx;
  assign updateCntIdx = updateIdx;
`endif

  always_comb begin
    btb_hit       = valid_q[lookupIdx] && (tag_q[lookupIdx] == lookupTag);
    predict_taken = btb_hit && counter_q[lookupCntIdx][1];
    branch_target = predict_taken ? target_q[lookupIdx] : pc + 32'd4;
  end

  always_comb begin
    counter_d = counter_q[updateCntIdx];
    if (update_taken) begin
      if (counter_q[updateCntIdx] != 2'b11) counter_d = counter_q[updateCntIdx] + 2'd1;
    end else begin
      if (counter_q[updateCntIdx] != 2'b00) counter_d = counter_q[updateCntIdx] - 2'd1;
    end
  end

  always_comb begin
    mispredCnt_d = mispredCnt_q;
    if (update_valid && (update_taken != update_predicted) && (mispredCnt_q != 16'hFFFF)) begin
      mispredCnt_d = mispredCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        counter_q[i] <= 2'b01;
      end
      valid_q      <= '0;
      mispredCnt_q <= '0;
    end else if (update_valid) begin
      counter_q[updateCntIdx] <= counter_d;
      if (update_taken) valid_q[updateIdx] <= 1'b1;
      mispredCnt_q <= mispredCnt_d;
    end
  end

  // Tags and targets need no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (update_valid && update_taken && !reset) begin
      tag_q[updateIdx]    <= updateTag;
      target_q[updateIdx] <= update_target;
    end
  end

  assign mispredict_count = mispredCnt_q;

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter BHT_ENTRIES, default 16, number of BHT/BTB entries; SHALL be a power of two, 4..256.
REQ-002 Parameter GHR_BITS, default 4, global history width; SHALL be no larger than log2(BHT_ENTRIES).
REQ-003 clk  input  1  single clock for all sequential logic; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pc  input  32  fetch-stage PC being looked up.
REQ-006 predict_taken  output  1  prediction for pc; 1 = taken; driven to InstructionFetch.
REQ-007 branch_target  output  32  next fetch address for pc.
REQ-008 btb_hit  output  1  BTB entry is valid and its tag matches pc.
REQ-009 update_valid  input  1  a resolved branch is presented this cycle.
REQ-010 update_pc  input  32  PC of the resolved branch.
REQ-011 update_taken  input  1  actual branch outcome.
REQ-012 update_target  input  32  actual taken target.
REQ-013 update_predicted  input  1  predict_taken value that was issued for this branch.
REQ-014 mispredict_count  output  16  number of resolved mispredictions, saturating.

Function
REQ-015 The index SHALL be IDX = pc[log2(BHT_ENTRIES)+1:2] (PC bits [1:0] ignored); the tag SHALL be pc[31:log2(BHT_ENTRIES)+2].
REQ-016 Each entry SHALL hold a 2-bit counter, a valid bit, a tag and a 32-bit target.
REQ-017 Counter encoding: 00 = SNT, 01 = WNT, 10 = WT, 11 = ST.
REQ-018 Lookup SHALL be combinational, with zero-cycle latency from pc to the outputs.
REQ-019 btb_hit SHALL equal valid[IDX] AND (tag[IDX] == pc tag).
REQ-020 predict_taken SHALL equal btb_hit AND counter[IDX][1].
REQ-021 branch_target SHALL be target[IDX] when predict_taken = 1, otherwise pc+4 (modulo 2^32; 0xFFFFFFFC wraps to 0x00000000).
REQ-022 When update_valid = 1, the entry at the update index SHALL be written on the next rising edge.
REQ-023 Counter update on taken: increment, saturating at ST (11).
REQ-024 Counter update on not-taken: decrement, saturating at SNT (00).
REQ-025 When update_taken = 1, the update SHALL also set valid = 1, write the tag from update_pc and write target = update_target.
REQ-026 When update_taken = 0, the BTB valid, tag and target SHALL be unchanged.
REQ-027 Simultaneous lookup and update of the same index: the lookup SHALL see the pre-update contents, with no bypass.
REQ-028 When update_valid = 1 and update_taken != update_predicted, mispredict_count SHALL increment by 1, holding at 0xFFFF.
REQ-029 When update_valid = 0, no state SHALL change.

Reset
REQ-030 While reset is asserted, all counters SHALL be WNT (01), all valid bits 0, GHR 0 and mispredict_count 0, regardless of clk.
REQ-031 Tags and targets MAY be left uninitialised; outputs SHALL be predict_taken = 0, btb_hit = 0 and branch_target = pc+4.
REQ-032 An update coincident with reset assertion SHALL be discarded.

Configuration
REQ-033 Macro GSHARE_EN defined: the counter index SHALL be IDX XOR zero-extended GHR for both lookup and update.
REQ-034 Macro GSHARE_EN defined: on each update the GHR SHALL shift left, inserting update_taken at bit 0.
REQ-035 Macro GSHARE_EN defined: the update index SHALL use the GHR value from before that shift.
REQ-036 Macro GSHARE_EN defined: BTB indexing SHALL remain IDX without the XOR.
REQ-037 Macro GSHARE_EN undefined: no GHR SHALL exist and the counter index SHALL be IDX.

Verification (default parameters, GSHARE_EN undefined unless stated)
REQ-038 Reset, then pc = 0x00000100 -> predict_taken = 0, btb_hit = 0, branch_target = 0x00000104.
REQ-039 Update 0x100 taken to target 0x200, update_predicted = 0, then pc = 0x100 -> btb_hit = 1, predict_taken = 1 (WT), branch_target = 0x200, mispredict_count = 1.
REQ-040 Three taken updates then four not-taken updates at 0x100 -> counter ST then SNT; predict_taken = 0, btb_hit = 1, branch_target = 0x104.
REQ-041 Alias test: entry trained at 0x100, then lookup pc = 0x140 -> btb_hit = 0, predict_taken = 0, branch_target = 0x144.
REQ-042 Set mispredict_count to 0xFFFF, apply one more mispredict -> count holds at 0xFFFF; assert reset mid-cycle -> all outputs return to reset values before the next edge.
REQ-043 GSHARE_EN defined: taken updates at 0x100 with GHR 0000 then 0001 -> counter writes land at indices 0 and 1; lookups use the matching XOR index.
